// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
package rv32i_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // One in-flight load: valid flag plus destination register.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when a valid scoreboard entry targets register r.
    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
        return e.v && (e.rd == r);
    endfunction

endpackage

// File: rtl/rv32i_hzScoreboard.sv
// Two-entry load scoreboard (loads in EX and MEM) plus the load-use match logic.
module rv32i_hzScoreboard
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ins_v,
    input  logic [4:0] i_ins_reg,
    input  logic       i_clear,
    input  logic       i_id_valid,
    input  logic [4:0] i_rs1_reg,
    input  logic       i_rs1_used,
    input  logic [4:0] i_rs2_reg,
    input  logic       i_rs2_used,
    output logic       o_haz
);

    sb_entry_t  r_sb_ex;
    sb_entry_t  r_sb_mem;
    logic [4:0] w_src [2];
    logic       w_used [2];
    logic [1:0] w_src_haz;

    assign w_src[0]  = i_rs1_reg;
    assign w_src[1]  = i_rs2_reg;
    assign w_used[0] = i_rs1_used;
    assign w_used[1] = i_rs2_used;

    // Each source operand hazards if it reads a register still owned by a load in EX or MEM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign w_src_haz[gi] = w_used[gi] && (w_src[gi] != REG_X0) &&
                                   (sb_hit(r_sb_ex, w_src[gi]) || sb_hit(r_sb_mem, w_src[gi]));
        end
    endgenerate

    assign o_haz = i_id_valid && (|w_src_haz);

    // Shift the load tracker one stage per cycle; bubbles and flushes enter as empty slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_ex  <= '0;
            r_sb_mem <= '0;
        end else begin
            r_sb_mem <= r_sb_ex;
            if (i_clear) begin
                r_sb_ex <= '0;
            end else begin
                r_sb_ex.v  <= i_ins_v;
                r_sb_ex.rd <= i_ins_reg;
            end
        end
    end

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, post-redirect flushes and perf counters.
module rv32i_hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1_reg,
    input  logic [4:0]        id_rs2_reg,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_wb_en,
    input  logic [4:0]        id_wb_reg,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if,
    output logic              flush_id,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    // Flush cycles still owed after the redirect cycle itself.
    localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);

    hz_state_t         r_state;
    hz_state_t         w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic              w_haz;
    logic              w_stall;
    logic              w_flush_id;
    logic              w_flush_if;
    logic              w_ins_v;
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_events;

    assign w_ins_v = id_valid && id_is_load && id_wb_en && (id_wb_reg != REG_X0);

    rv32i_hzScoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_ins_v    (w_ins_v),
        .i_ins_reg  (id_wb_reg),
        .i_clear    (w_stall || w_flush_id),
        .i_id_valid (id_valid),
        .i_rs1_reg  (id_rs1_reg),
        .i_rs1_used (id_rs1_used),
        .i_rs2_reg  (id_rs2_reg),
        .i_rs2_used (id_rs2_used),
        .o_haz      (w_haz)
    );

    // Next-state and outputs; a redirect always wins because the stalled ID instruction is younger.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_flush_id   = 1'b0;
        w_flush_if   = 1'b0;
        if (ex_redirect) begin
            w_flush_if   = 1'b1;
            w_flush_id   = 1'b1;
            w_cnt_next   = FC_M1;
            w_state_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (r_state)
                RUN, STALL: begin
                    w_stall      = w_haz;
                    w_state_next = w_haz ? STALL : RUN;
                end
                FLUSH: begin
                    w_flush_id = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_cnt_next   = 3'd0;
                        w_state_next = RUN;
                    end else begin
                        w_cnt_next = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_next = RUN;
                    w_cnt_next   = 3'd0;
                end
            endcase
        end
    end

    // Mode register and flush countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (ex_redirect && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign stall_if     = w_stall && !reset;
    assign stall_id     = w_stall && !reset;
    assign bubble_ex    = w_stall && !reset;
    assign flush_if     = w_flush_if && !reset;
    assign flush_id     = w_flush_id && !reset;
    assign busy         = (r_state != RUN) && !reset;
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Self-checking bench: directed vector table, saturation sequence, then random traffic vs. a cycle-level model.
module tb_rv32i_hazard_ctrl;

    localparam int FC     = 2;
    localparam int TB_PW  = 4;
    localparam int SATMAX = (1 << TB_PW) - 1;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       wb;
        logic [4:0] rd;
        logic       ld;
        logic       redir;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [5:0] ctrl;
        logic [3:0] st;
        logic [3:0] fl;
    } row_t;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1_reg;
    logic [4:0]       id_rs2_reg;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             id_wb_en;
    logic [4:0]       id_wb_reg;
    logic             id_is_load;
    logic             ex_redirect;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_if;
    logic             flush_id;
    logic             busy;
    logic [TB_PW-1:0] stall_cycles;
    logic [TB_PW-1:0] flush_events;

    rv32i_hazard_ctrl #(.FLUSH_CYCLES(FC), .PERF_W(TB_PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1_reg   (id_rs1_reg),
        .id_rs2_reg   (id_rs2_reg),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_wb_en     (id_wb_en),
        .id_wb_reg    (id_wb_reg),
        .id_is_load   (id_is_load),
        .ex_redirect  (ex_redirect),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Model: cycle at which each register's load result becomes forwardable.
    int ready_at [32];
    int t          = 0;
    int carry_rem  = 0;
    bit prev_stall = 1'b0;
    int m_stall    = 0;
    int m_flush    = 0;

    logic [5:0]       a_ctrl;
    logic [TB_PW-1:0] a_stall;
    logic [TB_PW-1:0] a_flush;

    row_t rows [$];

    function automatic in_t f_nop();
        in_t x;
        x = '0;
        return x;
    endfunction

    function automatic in_t f_load(input logic [4:0] rd, input logic [4:0] rs1);
        in_t x;
        x = '0;
        x.v = 1'b1; x.rs1 = rs1; x.u1 = 1'b1; x.wb = 1'b1; x.rd = rd; x.ld = 1'b1;
        return x;
    endfunction

    function automatic in_t f_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_t x;
        x = '0;
        x.v = 1'b1; x.rs1 = rs1; x.rs2 = rs2; x.u1 = 1'b1; x.u2 = 1'b1; x.wb = 1'b1; x.rd = rd;
        return x;
    endfunction

    function automatic in_t f_store(input logic [4:0] rs1, input logic [4:0] rs2);
        in_t x;
        x = '0;
        x.v = 1'b1; x.rs1 = rs1; x.rs2 = rs2; x.u1 = 1'b1; x.u2 = 1'b0;
        return x;
    endfunction

    function automatic in_t f_rst(input in_t a);
        in_t x;
        x = a;
        x.rst = 1'b1;
        return x;
    endfunction

    function automatic in_t f_redir(input in_t a);
        in_t x;
        x = a;
        x.redir = 1'b1;
        return x;
    endfunction

    task automatic add(input in_t i, input logic [5:0] c, input int st, input int fl);
        row_t r;
        r.i = i; r.ctrl = c; r.st = 4'(st); r.fl = 4'(fl);
        rows.push_back(r);
    endtask

    // One clock: drive inputs, check against the model at the falling edge, advance the model.
    task automatic cyc(input in_t v);
        int         rem;
        bit         haz;
        bit         stall;
        bit         bsy;
        logic [5:0] exp_ctrl;
        reset       = v.rst;
        id_valid    = v.v;
        id_rs1_reg  = v.rs1;
        id_rs2_reg  = v.rs2;
        id_rs1_used = v.u1;
        id_rs2_used = v.u2;
        id_wb_en    = v.wb;
        id_wb_reg   = v.rd;
        id_is_load  = v.ld;
        ex_redirect = v.redir;
        @(negedge clk);
        bsy   = prev_stall || (carry_rem > 0);
        rem   = v.redir ? FC : carry_rem;
        haz   = v.v && ((v.u1 && v.rs1 != 5'd0 && ready_at[v.rs1] > t) ||
                        (v.u2 && v.rs2 != 5'd0 && ready_at[v.rs2] > t));
        stall = haz && (rem == 0);
        exp_ctrl = v.rst ? 6'b0 : {stall, stall, stall, v.redir, (rem > 0), bsy};
        a_ctrl  = {stall_if, stall_id, bubble_ex, flush_if, flush_id, busy};
        a_stall = stall_cycles;
        a_flush = flush_events;
        checks++;
        if (a_ctrl !== exp_ctrl) begin
            errors++;
            $display("FAIL model_ctrl t=%0d got=%b want=%b", t, a_ctrl, exp_ctrl);
        end
        checks++;
        if (a_stall !== TB_PW'(m_stall) || a_flush !== TB_PW'(m_flush)) begin
            errors++;
            $display("FAIL model_perf t=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     t, a_stall, a_flush, m_stall, m_flush);
        end
        @(posedge clk);
        if (v.rst) begin
            foreach (ready_at[k]) ready_at[k] = 0;
            carry_rem  = 0;
            prev_stall = 1'b0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            if (!stall && rem == 0 && v.v && v.ld && v.wb && v.rd != 5'd0) ready_at[v.rd] = t + 3;
            carry_rem  = (rem > 0) ? rem - 1 : 0;
            prev_stall = stall;
            if (stall && m_stall < SATMAX) m_stall++;
            if (v.redir && m_flush < SATMAX) m_flush++;
        end
        t++;
        #1;
    endtask

    initial begin
        in_t r;
        foreach (ready_at[k]) ready_at[k] = 0;
        reset = 1'b1; id_valid = 1'b0; id_rs1_reg = '0; id_rs2_reg = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_wb_en = 1'b0; id_wb_reg = '0;
        id_is_load = 1'b0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ctrl bits: {stall_if, stall_id, bubble_ex, flush_if, flush_id, busy}
        add(f_rst(f_nop()),          6'b000000, 0, 0);
        add(f_load(5, 1),            6'b000000, 0, 0);
        add(f_alu(6, 5, 1),          6'b111000, 0, 0);
        add(f_alu(6, 5, 1),          6'b111001, 1, 0);
        add(f_alu(6, 5, 1),          6'b000001, 2, 0);
        add(f_nop(),                 6'b000000, 2, 0);
        add(f_load(5, 1),            6'b000000, 2, 0);
        add(f_alu(7, 1, 2),          6'b000000, 2, 0);
        add(f_alu(8, 5, 3),          6'b111000, 2, 0);
        add(f_alu(8, 5, 3),          6'b000001, 3, 0);
        add(f_load(0, 1),            6'b000000, 3, 0);
        add(f_alu(6, 0, 0),          6'b000000, 3, 0);
        add(f_load(5, 1),            6'b000000, 3, 0);
        add(f_store(9, 5),           6'b000000, 3, 0);
        add(f_nop(),                 6'b000000, 3, 0);
        add(f_nop(),                 6'b000000, 3, 0);
        add(f_redir(f_nop()),        6'b000110, 3, 0);
        add(f_nop(),                 6'b000011, 3, 1);
        add(f_nop(),                 6'b000000, 3, 1);
        add(f_load(5, 1),            6'b000000, 3, 1);
        add(f_redir(f_alu(6, 5, 1)), 6'b000110, 3, 1);
        add(f_alu(6, 5, 1),          6'b000011, 3, 2);
        add(f_alu(6, 5, 1),          6'b000000, 3, 2);
        add(f_load(5, 1),            6'b000000, 3, 2);
        add(f_alu(6, 5, 1),          6'b111000, 3, 2);
        add(f_redir(f_alu(6, 5, 1)), 6'b000111, 4, 2);
        add(f_alu(6, 5, 1),          6'b000011, 4, 3);
        add(f_alu(6, 5, 1),          6'b000000, 4, 3);
        add(f_load(5, 1),            6'b000000, 4, 3);
        add(f_load(7, 9),            6'b000000, 4, 3);
        add(f_alu(6, 5, 7),          6'b111000, 4, 3);
        add(f_rst(f_alu(6, 5, 7)),   6'b000000, 5, 3);
        add(f_alu(6, 5, 7),          6'b000000, 0, 0);

        for (int i = 0; i < rows.size(); i++) begin
            cyc(rows[i].i);
            checks++;
            if (a_ctrl !== rows[i].ctrl) begin
                errors++;
                $display("FAIL row%0d_ctrl got=%b want=%b", i, a_ctrl, rows[i].ctrl);
            end
            checks++;
            if (a_stall !== rows[i].st || a_flush !== rows[i].fl) begin
                errors++;
                $display("FAIL row%0d_perf got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         i, a_stall, a_flush, rows[i].st, rows[i].fl);
            end
        end

        // Saturation: 14 stall cycles, then 3 more must leave the 4-bit counter at 15.
        for (int k = 0; k < 7; k++) begin
            cyc(f_load(5, 1));
            repeat (3) cyc(f_alu(6, 5, 1));
        end
        cyc(f_nop());
        checks++;
        if (a_stall !== 4'd14) begin
            errors++;
            $display("FAIL sat_pre got=%0d want=14", a_stall);
        end
        cyc(f_load(5, 1));
        repeat (3) cyc(f_alu(6, 5, 1));
        cyc(f_load(5, 1));
        cyc(f_nop());
        cyc(f_alu(6, 5, 1));
        cyc(f_alu(6, 5, 1));
        cyc(f_nop());
        checks++;
        if (a_stall !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got=%0d want=15", a_stall);
        end

        // Random traffic against the model.
        cyc(f_rst(f_nop()));
        for (int k = 0; k < 2000; k++) begin
            r       = '0;
            r.rst   = ($urandom % 64) == 0;
            r.v     = ($urandom % 8) != 0;
            r.rs1   = 5'($urandom % 8);
            r.rs2   = 5'($urandom % 8);
            r.u1    = 1'($urandom);
            r.u2    = 1'($urandom);
            r.wb    = ($urandom % 4) != 0;
            r.rd    = 5'($urandom % 8);
            r.ld    = ($urandom % 3) == 0;
            r.redir = ($urandom % 16) == 0;
            cyc(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
